// File: rtl/uart_reg_bridge_pkg.sv
// rtl/uart_reg_bridge_pkg.sv - frame states and command/reply byte codes for uart_reg_bridge
// Honours UART_REG_BRIDGE_CHECKSUM_EN (adds the GET_SUM state).
package uart_reg_bridge_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_GET_ADDR,
    S_GET_DH,
    S_GET_DL,
`ifdef UART_REG_BRIDGE_CHECKSUM_EN
    S_GET_SUM,
`endif
    S_BUS,
    S_SEND0,
    S_SEND1
  } state_t;

  localparam logic [7:0] CMD_WR  = 8'h57;
  localparam logic [7:0] CMD_RD  = 8'h52;
  localparam logic [7:0] RSP_OK  = 8'h4B;
  localparam logic [7:0] RSP_BAD = 8'h3F;
  localparam logic [7:0] RSP_TMO = 8'h54;
  localparam logic [7:0] RSP_SUM = 8'h45;

  // States in which the byte timeout runs (frame started, more bytes owed).
  function automatic logic is_get(input state_t s);
`ifdef UART_REG_BRIDGE_CHECKSUM_EN
    return (s == S_GET_ADDR) || (s == S_GET_DH) || (s == S_GET_DL) || (s == S_GET_SUM);
`else
    return (s == S_GET_ADDR) || (s == S_GET_DH) || (s == S_GET_DL);
`endif
  endfunction

endpackage

// File: rtl/uart_bridge_timer.sv
// rtl/uart_bridge_timer.sv - up-counter with clear, run enable and terminal flag at a loadable limit
module uart_bridge_timer #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             enable,
  input  logic [WIDTH-1:0] limit,
  output logic             done
);

  logic [WIDTH-1:0] count;

  assign done = (count == limit);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && !done) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/uart_reg_bridge.sv
// rtl/uart_reg_bridge.sv - UART byte-frame to register-bus master
// Optional request/reply checksum byte: define UART_REG_BRIDGE_CHECKSUM_EN.
module uart_reg_bridge
  import uart_reg_bridge_pkg::*;
#(
  parameter int BYTE_TIMEOUT = 50000,
  parameter int BUS_TIMEOUT  = 255,
  parameter int ADDR_W       = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              rx_valid,
  input  logic [7:0]        rxdata,
  output logic              read_rx,
  input  logic              tx_empty,
  output logic [7:0]        txdata,
  output logic              write_tx,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [15:0]       bus_wdata,
  output logic              bus_wr,
  output logic              bus_rd,
  input  logic [15:0]       bus_rdata,
  input  logic              bus_ack,
  output logic              busy,
  output logic [7:0]        err_count
);

  localparam int BYTE_W = $clog2(BYTE_TIMEOUT + 1);
  localparam int BUS_W  = $clog2(BUS_TIMEOUT + 1);
  localparam logic [BYTE_W-1:0] BYTE_LIM = BYTE_W'(BYTE_TIMEOUT - 1);
  localparam logic [BUS_W-1:0]  BUS_LIM  = BUS_W'(BUS_TIMEOUT - 1);
`ifdef UART_REG_BRIDGE_CHECKSUM_EN
  localparam state_t S_REQ_END = S_GET_SUM;
`else
  localparam state_t S_REQ_END = S_BUS;
`endif

  state_t            state, state_next;
  logic              pop, push, pop_q, push_q;
  logic              is_wr, err_inc, rsp_load;
  logic [23:0]       rsp_buf, rsp_val;
  logic [1:0]        tx_left, rsp_len;
  logic [ADDR_W-1:0] addr;
  logic [15:0]       wdata;
  logic              byte_done, bus_done;
`ifdef UART_REG_BRIDGE_CHECKSUM_EN
  logic [7:0]        sum;
`endif

  uart_bridge_timer #(.WIDTH(BYTE_W)) u_byte_timer (
    .clk(clk), .reset(reset), .clear(pop || !is_get(state)), .enable(is_get(state)),
    .limit(BYTE_LIM), .done(byte_done)
  );

  uart_bridge_timer #(.WIDTH(BUS_W)) u_bus_timer (
    .clk(clk), .reset(reset), .clear(state != S_BUS), .enable(state == S_BUS),
    .limit(BUS_LIM), .done(bus_done)
  );

  assign read_rx   = pop;
  assign write_tx  = push;
  assign txdata    = rsp_buf[23:16];
  assign bus_addr  = addr;
  assign bus_wdata = wdata;
  assign bus_wr    = (state == S_BUS) && is_wr;
  assign bus_rd    = (state == S_BUS) && !is_wr;
  assign busy      = (state != S_IDLE);

  always_comb begin
    // pop_q masks the stale rx_valid the UART still shows right after a pop
    pop        = rx_valid && !pop_q && !reset && ((state == S_IDLE) || is_get(state));
    push       = ((state == S_SEND0) || (state == S_SEND1)) && tx_empty && !push_q;
    state_next = state;
    err_inc    = 1'b0;
    rsp_load   = 1'b0;
    rsp_val    = 24'h0;
    rsp_len    = 2'd0;
    case (state)
      S_IDLE: if (pop) begin
        if ((rxdata == CMD_WR) || (rxdata == CMD_RD)) begin
          state_next = S_GET_ADDR;
        end else begin
          state_next = S_SEND0;
          rsp_load   = 1'b1;
          rsp_val    = {RSP_BAD, 16'h0};
          rsp_len    = 2'd1;
          err_inc    = 1'b1;
        end
      end
      S_GET_ADDR: if (pop) state_next = is_wr ? S_GET_DH : S_REQ_END;
      S_GET_DH:   if (pop) state_next = S_GET_DL;
      S_GET_DL:   if (pop) state_next = S_REQ_END;
`ifdef UART_REG_BRIDGE_CHECKSUM_EN
      S_GET_SUM: if (pop) begin
        if (rxdata == sum) begin
          state_next = S_BUS;
        end else begin
          state_next = S_SEND0;
          rsp_load   = 1'b1;
          rsp_val    = {RSP_SUM, 16'h0};
          rsp_len    = 2'd1;
          err_inc    = 1'b1;
        end
      end
`endif
      S_BUS: begin
        if (bus_ack) begin
          state_next = S_SEND0;
          rsp_load   = 1'b1;
          if (is_wr) begin
            rsp_val = {RSP_OK, 16'h0};
            rsp_len = 2'd1;
          end else begin
`ifdef UART_REG_BRIDGE_CHECKSUM_EN
            rsp_val = {bus_rdata, bus_rdata[15:8] ^ bus_rdata[7:0]};
            rsp_len = 2'd3;
`else
            rsp_val = {bus_rdata, 8'h00};
            rsp_len = 2'd2;
`endif
          end
        end else if (bus_done) begin
          state_next = S_SEND0;
          rsp_load   = 1'b1;
          rsp_val    = {RSP_TMO, 16'h0};
          rsp_len    = 2'd1;
          err_inc    = 1'b1;
        end
      end
      S_SEND0, S_SEND1: if (push) state_next = (tx_left == 2'd1) ? S_IDLE : S_SEND1;
      default: state_next = S_IDLE;
    endcase
    // a byte popped in the expiry cycle keeps the frame alive
    if (is_get(state) && !pop && byte_done) begin
      state_next = S_IDLE;
      err_inc    = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= S_IDLE;
      pop_q     <= 1'b0;
      push_q    <= 1'b0;
      is_wr     <= 1'b0;
      addr      <= '0;
      wdata     <= 16'h0;
      rsp_buf   <= 24'h0;
      tx_left   <= 2'd0;
      err_count <= 8'h0;
`ifdef UART_REG_BRIDGE_CHECKSUM_EN
      sum       <= 8'h0;
`endif
    end else begin
      state  <= state_next;
      pop_q  <= pop;
      push_q <= push;
      if (pop) begin
`ifdef UART_REG_BRIDGE_CHECKSUM_EN
        sum <= (state == S_IDLE) ? rxdata : (sum ^ rxdata);
`endif
        case (state)
          S_IDLE:     is_wr <= (rxdata == CMD_WR);
          S_GET_ADDR: addr <= rxdata[ADDR_W-1:0];
          S_GET_DH:   wdata[15:8] <= rxdata;
          S_GET_DL:   wdata[7:0] <= rxdata;
          default: ;
        endcase
      end
      if (rsp_load) begin
        rsp_buf <= rsp_val;
        tx_left <= rsp_len;
      end else if (push) begin
        rsp_buf <= {rsp_buf[15:0], 8'h00};
        tx_left <= tx_left - 2'd1;
      end
      if (err_inc && (err_count != 8'hFF)) err_count <= err_count + 8'd1;
    end
  end

endmodule
